// File: rtl/switch_rr_arb.sv
// N-port crossbar switch with per-output round-robin arbitration,
// registered outputs and a saturating illegal-route drop counter.
module switch_rr_arb #(
   parameter int N_PORTS   = 6,
   parameter int ROUTE_LEN = 3,
   parameter int FLIT_W    = 85,
   parameter int ERR_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_PORTS*FLIT_W-1:0]    in,
   input  logic [N_PORTS*ROUTE_LEN-1:0] route_in,
   input  logic [N_PORTS-1:0]           in_valid,
   input  logic [N_PORTS-1:0]           out_avail,
   output logic [N_PORTS-1:0]           in_avail,
   output logic [N_PORTS-1:0]           out_valid,
   output logic [N_PORTS*FLIT_W-1:0]    out,
   output logic [ERR_W-1:0]             err_cnt
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CW = $clog2(N_PORTS + 1);
   localparam int SW = ((ERR_W > CW) ? ERR_W : CW) + 1;

   logic [N_PORTS-1:0][ROUTE_LEN-1:0] route_code;
   logic [N_PORTS-1:0]                illegal;
   logic [N_PORTS-1:0][N_PORTS-1:0]   req;
   logic [N_PORTS-1:0][N_PORTS-1:0]   gnt;
   logic [N_PORTS-1:0]                can_load;
   logic [N_PORTS-1:0]                grant_any;
   logic [N_PORTS-1:0][PW-1:0]        winner;
   logic [N_PORTS-1:0][PW-1:0]        rr_ptr;
   logic [N_PORTS-1:0][PW-1:0]        ptr_next;
   logic [N_PORTS-1:0][FLIT_W-1:0]    gnt_data;
   logic [CW-1:0]                     ill_cnt;
   logic [SW-1:0]                     err_sum;
   logic [ERR_W-1:0]                  err_next;

   always_comb begin
      route_code = '0;
      illegal    = '0;
      req        = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         route_code[i] = route_in[i*ROUTE_LEN +: ROUTE_LEN];
         illegal[i] = in_valid[i] &&
                      ((route_code[i] == '0) ||
                       (route_code[i] > ROUTE_LEN'(N_PORTS)));
         for (int o = 0; o < N_PORTS; o++) begin
            req[o][i] = in_valid[i] &&
                        (route_code[i] == ROUTE_LEN'(o + 1));
         end
      end
   end

   // Scan upward from rr_ptr with wrap; the first requester wins.
   always_comb begin
      int idx;
      idx       = 0;
      can_load  = '0;
      grant_any = '0;
      winner    = '0;
      gnt       = '0;
      ptr_next  = rr_ptr;
      gnt_data  = '0;
      for (int o = 0; o < N_PORTS; o++) begin
         can_load[o] = !out_valid[o] || out_avail[o];
         for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(rr_ptr[o]) + k;
            if (idx >= N_PORTS) begin
               idx = idx - N_PORTS;
            end
            if (can_load[o] && !grant_any[o] && req[o][idx]) begin
               grant_any[o] = 1'b1;
               winner[o]    = PW'(idx);
            end
         end
         if (grant_any[o]) begin
            gnt[o][winner[o]] = 1'b1;
            gnt_data[o] = in[int'(winner[o])*FLIT_W +: FLIT_W];
            if (winner[o] == PW'(N_PORTS - 1)) begin
               ptr_next[o] = '0;
            end else begin
               ptr_next[o] = winner[o] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_avail = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         in_avail[i] = illegal[i];
         for (int o = 0; o < N_PORTS; o++) begin
            if (gnt[o][i]) begin
               in_avail[i] = 1'b1;
            end
         end
         if (!rst) begin
            in_avail[i] = 1'b0;
         end
      end
   end

   always_comb begin
      ill_cnt = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         ill_cnt = ill_cnt + CW'(illegal[i]);
      end
      err_sum = SW'(err_cnt) + SW'(ill_cnt);
      if (err_sum > SW'({ERR_W{1'b1}})) begin
         err_next = {ERR_W{1'b1}};
      end else begin
         err_next = err_sum[ERR_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= '0;
         out       <= '0;
         rr_ptr    <= '0;
         err_cnt   <= '0;
      end else begin
         err_cnt <= err_next;
         for (int o = 0; o < N_PORTS; o++) begin
            if (grant_any[o]) begin
               out_valid[o] <= 1'b1;
               out[o*FLIT_W +: FLIT_W] <= gnt_data[o];
               rr_ptr[o] <= ptr_next[o];
            end else if (out_avail[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_rr_arb.sv
// Bench for switch_rr_arb: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_switch_rr_arb;

   localparam int N  = 6;
   localparam int FW = 85;
   localparam int RL = 3;
   localparam int PN = 4;
   localparam int PF = 32;

   logic clk;
   logic rst;
   logic [N*FW-1:0] in_bus;
   logic [N*RL-1:0] route_bus;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    out_avail;
   logic [N-1:0]    in_avail;
   logic [N-1:0]    out_valid;
   logic [N*FW-1:0] out_bus;
   logic [15:0]     err_cnt;

   logic [N-1:0]    in_avail_e;
   logic [N-1:0]    out_valid_e;
   logic [N*FW-1:0] out_e;
   logic [1:0]      err_e;

   logic [PN*PF-1:0] p_in;
   logic [PN*RL-1:0] p_route;
   logic [PN-1:0]    p_valid;
   logic [PN-1:0]    p_oavail;
   logic [PN-1:0]    p_iavail;
   logic [PN-1:0]    p_ovalid;
   logic [PN*PF-1:0] p_out;
   logic [15:0]      p_err;

   int checks;
   int errors;

   switch_rr_arb dut (
      .clk(clk), .rst(rst), .in(in_bus), .route_in(route_bus),
      .in_valid(in_valid), .out_avail(out_avail),
      .in_avail(in_avail), .out_valid(out_valid),
      .out(out_bus), .err_cnt(err_cnt)
   );

   switch_rr_arb #(.ERR_W(2)) dut_e (
      .clk(clk), .rst(rst), .in(in_bus), .route_in(route_bus),
      .in_valid(in_valid), .out_avail(out_avail),
      .in_avail(in_avail_e), .out_valid(out_valid_e),
      .out(out_e), .err_cnt(err_e)
   );

   switch_rr_arb #(.N_PORTS(PN), .ROUTE_LEN(RL), .FLIT_W(PF)) dut_p (
      .clk(clk), .rst(rst), .in(p_in), .route_in(p_route),
      .in_valid(p_valid), .out_avail(p_oavail),
      .in_avail(p_iavail), .out_valid(p_ovalid),
      .out(p_out), .err_cnt(p_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // reference model: state per output, plus next-state shadow
   logic          m_vld [N];
   logic [FW-1:0] m_dat [N];
   int            m_ptr [N];
   int            m_err;
   int            m_err_e;
   logic          n_vld [N];
   logic [FW-1:0] n_dat [N];
   int            n_ptr [N];
   int            n_err;
   int            n_err_e;
   logic [N-1:0]  m_avail;

   function automatic int route_of(int i);
      logic [RL-1:0] r;
      r = route_bus[i*RL +: RL];
      return int'(r);
   endfunction

   task automatic model_eval();
      int cnt;
      int w;
      int i;
      m_avail = '0;
      cnt = 0;
      for (int o = 0; o < N; o++) begin
         n_vld[o] = m_vld[o];
         n_dat[o] = m_dat[o];
         n_ptr[o] = m_ptr[o];
      end
      if (!rst) begin
         for (int o = 0; o < N; o++) begin
            n_vld[o] = 1'b0;
            n_dat[o] = '0;
            n_ptr[o] = 0;
         end
         n_err = 0;
         n_err_e = 0;
         return;
      end
      for (int j = 0; j < N; j++) begin
         if (in_valid[j] && (route_of(j) == 0 || route_of(j) > N)) begin
            m_avail[j] = 1'b1;
            cnt++;
         end
      end
      for (int o = 0; o < N; o++) begin
         if (!m_vld[o] || out_avail[o]) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               i = (m_ptr[o] + k) % N;
               if (w < 0 && in_valid[i] && route_of(i) == o + 1) w = i;
            end
            if (w >= 0) begin
               n_vld[o] = 1'b1;
               n_dat[o] = in_bus[w*FW +: FW];
               n_ptr[o] = (w + 1) % N;
               m_avail[w] = 1'b1;
            end else begin
               n_vld[o] = 1'b0;
            end
         end
      end
      n_err   = (m_err + cnt > 65535) ? 65535 : m_err + cnt;
      n_err_e = (m_err_e + cnt > 3) ? 3 : m_err_e + cnt;
   endtask

   task automatic adv();
      model_eval();
      @(posedge clk);
      #1;
      for (int o = 0; o < N; o++) begin
         m_vld[o] = n_vld[o];
         m_dat[o] = n_dat[o];
         m_ptr[o] = n_ptr[o];
      end
      m_err = n_err;
      m_err_e = n_err_e;
   endtask

   task automatic idle_inputs();
      in_bus = '0;
      route_bus = '0;
      in_valid = '0;
      out_avail = '1;
      p_in = '0;
      p_route = '0;
      p_valid = '0;
      p_oavail = '1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      adv();
      adv();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      in_valid = '1;
      for (int i = 0; i < N; i++) route_bus[i*RL +: RL] = 3'(i + 1);
      #1;
      checks++;
      if (in_avail !== '0) begin
         $display("FAIL reset_in_avail: got %b want 0", in_avail);
         errors++;
      end
      adv();
      checks++;
      if (out_valid !== '0 || out_bus !== '0 || err_cnt !== '0) begin
         $display("FAIL reset_state: out_valid=%b err=%0d out!=0:%b",
                  out_valid, err_cnt, |out_bus);
         errors++;
      end
      checks++;
      if (in_avail !== '0) begin
         $display("FAIL reset_hold_avail: got %b want 0", in_avail);
         errors++;
      end
      idle_inputs();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_single();
      do_reset();
      in_valid = 6'b000100;
      in_bus[2*FW +: FW] = FW'(8'h15);
      route_bus[2*RL +: RL] = 3'd1;
      #1;
      checks++;
      if (in_avail !== 6'b000100) begin
         $display("FAIL single_in_avail: got %b want 000100", in_avail);
         errors++;
      end
      adv();
      checks++;
      if (out_valid !== 6'b000001 || out_bus[0 +: FW] !== FW'(8'h15)) begin
         $display("FAIL single_out: valid=%b out0=%h want 000001/15",
                  out_valid, out_bus[0 +: FW]);
         errors++;
      end
      in_valid = '0;
      adv();
      checks++;
      if (out_valid !== '0) begin
         $display("FAIL single_drain: valid=%b want 0", out_valid);
         errors++;
      end
   endtask

   task automatic test_contention();
      int exp_src [6] = '{0, 3, 5, 0, 3, 5};
      logic [N-1:0] ea;
      do_reset();
      in_valid = 6'b101001;
      for (int i = 0; i < N; i++) begin
         route_bus[i*RL +: RL] = 3'd2;
         in_bus[i*FW +: FW] = FW'(i + 8'h40);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         ea = '0;
         ea[exp_src[k]] = 1'b1;
         checks++;
         if (in_avail !== ea) begin
            $display("FAIL contention_avail[%0d]: got %b want %b",
                     k, in_avail, ea);
            errors++;
         end
         adv();
         checks++;
         if (out_valid !== 6'b000010 ||
             out_bus[FW +: FW] !== FW'(exp_src[k] + 8'h40)) begin
            $display("FAIL contention_out[%0d]: valid=%b out1=%h want src %0d",
                     k, out_valid, out_bus[FW +: FW], exp_src[k]);
            errors++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [FW-1:0] a;
      logic [FW-1:0] b;
      a = FW'({$urandom, $urandom, $urandom});
      b = ~a;
      do_reset();
      in_valid = 6'b000100;
      route_bus[2*RL +: RL] = 3'd5;
      in_bus[2*FW +: FW] = a;
      adv();
      in_valid = 6'b000010;
      route_bus[1*RL +: RL] = 3'd5;
      in_bus[1*FW +: FW] = b;
      in_bus[2*FW +: FW] = '0;
      out_avail = 6'b101111;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (in_avail[1] !== 1'b0) begin
            $display("FAIL bp_avail[%0d]: got %b want 0", k, in_avail[1]);
            errors++;
         end
         adv();
         checks++;
         if (out_valid[4] !== 1'b1 || out_bus[4*FW +: FW] !== a) begin
            $display("FAIL bp_hold[%0d]: valid=%b out4=%h want %h",
                     k, out_valid[4], out_bus[4*FW +: FW], a);
            errors++;
         end
      end
      out_avail = '1;
      #1;
      checks++;
      if (in_avail !== 6'b000010) begin
         $display("FAIL bp_refill_avail: got %b want 000010", in_avail);
         errors++;
      end
      adv();
      checks++;
      if (out_valid !== 6'b010000 || out_bus[4*FW +: FW] !== b) begin
         $display("FAIL bp_refill: valid=%b out4=%h want %h",
                  out_valid, out_bus[4*FW +: FW], b);
         errors++;
      end
   endtask

   task automatic test_illegal();
      int e;
      do_reset();
      in_valid = 6'b010010;
      route_bus[1*RL +: RL] = 3'd0;
      route_bus[4*RL +: RL] = 3'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (in_avail !== 6'b010010) begin
            $display("FAIL illegal_avail[%0d]: got %b want 010010",
                     k, in_avail);
            errors++;
         end
         adv();
         e = 2 * (k + 1);
         checks++;
         if (out_valid !== '0 || err_cnt !== 16'(e)) begin
            $display("FAIL illegal_cnt[%0d]: valid=%b err=%0d want 0/%0d",
                     k, out_valid, err_cnt, e);
            errors++;
         end
         checks++;
         if (err_e !== 2'((e > 3) ? 3 : e)) begin
            $display("FAIL illegal_sat[%0d]: err=%0d want %0d",
                     k, err_e, (e > 3) ? 3 : e);
            errors++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = '1;
      adv();
      for (int i = 0; i < N; i++) begin
         route_bus[i*RL +: RL] = 3'(i + 1);
         in_bus[i*FW +: FW] = FW'(i + 8'h80);
      end
      out_avail = '0;
      adv();
      checks++;
      if (out_valid !== 6'h3f || err_cnt !== 16'd6) begin
         $display("FAIL mid_fill: valid=%b err=%0d want 111111/6",
                  out_valid, err_cnt);
         errors++;
      end
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== '0 || err_cnt !== '0 || in_avail !== '0) begin
         $display("FAIL mid_reset: valid=%b err=%0d avail=%b want 0",
                  out_valid, err_cnt, in_avail);
         errors++;
      end
      adv();
      rst = 1'b1;
      out_avail = '1;
      for (int i = 0; i < N; i++) route_bus[i*RL +: RL] = 3'd1;
      #1;
      checks++;
      if (in_avail !== 6'b000001) begin
         $display("FAIL mid_rr_start: got %b want 000001", in_avail);
         errors++;
      end
      adv();
      checks++;
      if (out_valid !== 6'b000001 || out_bus[0 +: FW] !== FW'(8'h80)) begin
         $display("FAIL mid_first: valid=%b out0=%h want 000001/80",
                  out_valid, out_bus[0 +: FW]);
         errors++;
      end
   endtask

   task automatic test_param();
      logic [PF-1:0] d [PN];
      int t;
      do_reset();
      p_valid = '1;
      p_oavail = '1;
      for (int i = 0; i < PN; i++) p_route[i*RL +: RL] = 3'((i + 1) % PN + 1);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < PN; i++) begin
            d[i] = $urandom;
            p_in[i*PF +: PF] = d[i];
         end
         #1;
         checks++;
         if (p_iavail !== 4'hf) begin
            $display("FAIL param_avail[%0d]: got %b want 1111", k, p_iavail);
            errors++;
         end
         adv();
         for (int i = 0; i < PN; i++) begin
            t = (i + 1) % PN;
            checks++;
            if (p_ovalid !== 4'hf || p_out[t*PF +: PF] !== d[i]) begin
               $display("FAIL param_out[%0d][%0d]: valid=%b out=%h want %h",
                        k, t, p_ovalid, p_out[t*PF +: PF], d[i]);
               errors++;
            end
         end
      end
      p_valid = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] ev;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            in_bus[i*FW +: FW] = FW'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 9) < 2)
               route_bus[i*RL +: RL] = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0;
            else
               route_bus[i*RL +: RL] = 3'($urandom_range(1, 3));
            in_valid[i] = ($urandom_range(0, 3) != 0);
            out_avail[i] = ($urandom_range(0, 3) != 0);
         end
         #1;
         model_eval();
         checks++;
         if (in_avail !== m_avail || in_avail_e !== m_avail) begin
            $display("FAIL rand_avail[%0d]: got %b/%b want %b",
                     c, in_avail, in_avail_e, m_avail);
            errors++;
         end
         adv();
         for (int o = 0; o < N; o++) ev[o] = m_vld[o];
         checks++;
         if (out_valid !== ev || err_cnt !== 16'(m_err) ||
             err_e !== 2'(m_err_e)) begin
            $display("FAIL rand_state[%0d]: valid=%b err=%0d/%0d want %b %0d/%0d",
                     c, out_valid, err_cnt, err_e, ev, m_err, m_err_e);
            errors++;
         end
         for (int o = 0; o < N; o++) begin
            if (m_vld[o]) begin
               checks++;
               if (out_bus[o*FW +: FW] !== m_dat[o]) begin
                  $display("FAIL rand_data[%0d][%0d]: got %h want %h",
                           c, o, out_bus[o*FW +: FW], m_dat[o]);
                  errors++;
               end
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      idle_inputs();
      for (int o = 0; o < N; o++) begin
         m_vld[o] = 1'b0;
         m_dat[o] = '0;
         m_ptr[o] = 0;
      end
      m_err = 0;
      m_err_e = 0;
      #2;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_param();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
